dma_channel: RTL and testbench
==============================

// Module: dma_channel
// PURPOSE
//  Single GBA-style DMA channel; bus master directly upstream of the memory block.
//  Copies cfg_count halfwords/words from src to dst over the shared mem_* bus.
//  Bus ownership: bus_req/bus_gnt handshake with the CPU. Top level muxes mem_* and tristates mem_data.
// PARAMETERS
//  CNT_W   14  unit-count width; cfg_count==0 means 2**CNT_W units
//  ADDR_W  28  significant address bits; mem_addr[31:ADDR_W] driven 0
// PORTS
//  clk          in   1   system clock (same clk as memory)
//  rst_n        in   1   asynchronous active-low reset
//  cfg_enable   in   1   channel enable bit from io registers
//  cfg_src      in   32  source address
//  cfg_dst      in   32  destination address
//  cfg_count    in   CNT_W  unit count
//  cfg_src_ctl  in   2   0 inc, 1 dec, 2 fixed, 3 treated as inc
//  cfg_dst_ctl  in   2   0 inc, 1 dec, 2 fixed, 3 inc+reload on repeat
//  cfg_word     in   1   1: 32-bit units, 0: 16-bit units
//  cfg_repeat   in   1   re-arm after block when timing != immediate
//  cfg_timing   in   2   0 immediate, 1 vblank, 2 hblank, 3 never
//  cfg_irq_en   in   1   pulse irq at block end
//  vblank_pls   in   1   one-cycle vblank trigger
//  hblank_pls   in   1   one-cycle hblank trigger
//  bus_req      out  1   request bus from CPU
//  bus_gnt      in   1   CPU has released the bus
//  mem_addr     out  32  access address, aligned to unit size
//  mem_wdata    out  32  write data; halfwords replicated in [31:16] and [15:0]
//  mem_wdata_oe out  1   drive mem_data from mem_wdata
//  mem_rdata    in   32  mem_data as read back
//  mem_width    out  2   1 halfword, 2 word
//  mem_read     out  1   read strobe
//  mem_write    out  1   write strobe
//  mem_ok       in   1   memory ok; low = stall (loader active / unaligned RMW)
//  irq          out  1   one-cycle block-done pulse
//  enable_clr   out  1   one-cycle pulse; io regs must clear cfg_enable
//  active       out  1   high from REQ to DONE inclusive
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; internal src/dst/count registers cleared.
//  FSM: IDLE, ARMED, REQ, RD_A, RD_D, WR, DONE.
//  IDLE: on cfg_enable 0->1, latch src, dst, count into working registers and go ARMED.
//    Latch src/dst masked to ADDR_W bits with low bits forced to unit alignment.
//  ARMED: timing 0 -> REQ next cycle; 1/2 -> REQ on matching pulse; 3 waits.
//  REQ: bus_req=1; go RD_A on cycle bus_gnt sampled 1. bus_req stays 1 through WR, drops in DONE.
//  RD_A: mem_read=1, mem_addr=src; 1 cycle.
//  RD_D: mem_read held, same addr (synchronous RAM data valid).
//    Latch mem_rdata at posedge with mem_ok=1; else stay.
//  WR: mem_write=1, mem_wdata_oe=1, mem_addr=dst. Minimum 2 cycles.
//    Complete at first posedge after entry cycle with mem_ok=1.
//    This covers the memory's one-cycle ok-low read-modify-write on halfword writes.
//  On WR complete: src/dst step +-2 or +-4 per ctl; count-1.
//    count reaches 0 -> DONE; else RD_A.
//  Aligned word unit, no stall: 4 cycles (RD_A, RD_D, WR x2).
//  DONE (1 cycle): irq=cfg_irq_en. Then:
//    repeat && timing!=0: reload count from cfg_count; reload dst only if dst_ctl=3; -> ARMED.
//    otherwise: enable_clr=1 -> IDLE.
//  Address arithmetic wraps modulo 2**ADDR_W; no bounds checks.
//  cfg_enable falling outside RD_A..WR: -> IDLE next cycle, no irq, no enable_clr.
//  cfg_enable falling mid-unit: current unit completes its write, then IDLE; bus_req drops.
//  Trigger pulse arriving while not in ARMED is dropped (no queue).
//  bus_gnt deasserting mid-block is a CPU protocol violation; ignored.
//  cfg_* changes after latch have no effect until the next IDLE->ARMED or repeat reload.
//  rst_n assertion mid-access: strobes drop immediately (async); a partial write is not retried.
// STRUCTURE
//  Shared package dma_pkg: state encoding, ctl codes (INC/DEC/FIXED/RELOAD), timing codes,
//    WIDTH_HALF=2'h1, WIDTH_WORD=2'h2.
//  One sub-module: dma_addr_step (addr, ctl, word -> next addr); instantiated twice, src and dst.
// TESTING
//  1. Immediate, word, inc/inc, src 0x02000000, dst 0x03000000, count 4:
//     4 reads then 4 writes, interleaved; 16 data cycles; dst ends 0x03000010; irq + enable_clr once.
//  2. Halfword, src_ctl=dec from 0x0300001E, count 3:
//     reads 0x1E, 0x1C, 0x1A; writes carry value in both halves; mem_width=1.
//  3. CNT_W=4, count=0: exactly 16 units transferred.
//  4. timing=vblank, repeat, dst_ctl=3:
//     nothing before pulse; each pulse copies block to the same dst; enable_clr never.
//  5. Force mem_ok=0 for 5 cycles in RD_D and in WR:
//     address/strobes held stable; data correct; unit stretches by 5 cycles.
//  6. Drop cfg_enable during unit 2 of 4: unit 2 write completes, IDLE, no irq.
//     rst_n low mid-WR: all outputs 0 asynchronously.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and codes for the DMA channel: FSM states, address/timing controls,
// bus width codes and the latched per-block configuration record.
package dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_REQ   = 3'd2,
      ST_RD_A  = 3'd3,
      ST_RD_D  = 3'd4,
      ST_WR    = 3'd5,
      ST_DONE  = 3'd6
   } dma_state_t;

   typedef enum logic [1:0] {
      CTL_INC    = 2'd0,
      CTL_DEC    = 2'd1,
      CTL_FIXED  = 2'd2,
      CTL_RELOAD = 2'd3
   } dma_ctl_t;

   typedef enum logic [1:0] {
      TIM_IMM    = 2'd0,
      TIM_VBLANK = 2'd1,
      TIM_HBLANK = 2'd2,
      TIM_NEVER  = 2'd3
   } dma_timing_t;

   localparam logic [1:0] WIDTH_HALF = 2'h1;
   localparam logic [1:0] WIDTH_WORD = 2'h2;

   typedef struct packed {
      logic        word;
      dma_ctl_t    src_ctl;
      dma_ctl_t    dst_ctl;
      dma_timing_t timing;
      logic        rpt;
      logic        irq_en;
   } dma_cfg_t;

   function automatic logic [1:0] unit_width(input logic word);
      return word ? WIDTH_WORD : WIDTH_HALF;
   endfunction

endpackage

// File: rtl/dma_addr_step.sv
// Next-address computation for one DMA pointer: step by one unit (2 or 4 bytes)
// up, down or not at all. Arithmetic wraps within ADDR_W bits.
module dma_addr_step
   import dma_pkg::*;
#(
   parameter int unsigned ADDR_W = 28
) (
   input  logic [ADDR_W-1:0] addr,
   input  dma_ctl_t          ctl,
   input  logic              word,
   output logic [ADDR_W-1:0] next
);

   logic [ADDR_W-1:0] step;

   assign step = word ? ADDR_W'(4) : ADDR_W'(2);

   // Reload mode only differs at block end; within a block it increments.
   always_comb begin
      next = addr + step;
      unique case (ctl)
         CTL_DEC:   next = addr - step;
         CTL_FIXED: next = addr;
         default:   next = addr + step;
      endcase
   end

endmodule

// File: rtl/dma_channel.sv
// Single DMA channel: arms on enable, waits for its trigger, takes the bus and
// copies a block of halfword/word units from src to dst one read/write pair at a time.
module dma_channel
   import dma_pkg::*;
#(
   parameter int unsigned CNT_W  = 14,
   parameter int unsigned ADDR_W = 28
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_enable,
   input  logic [31:0]      cfg_src,
   input  logic [31:0]      cfg_dst,
   input  logic [CNT_W-1:0] cfg_count,
   input  logic [1:0]       cfg_src_ctl,
   input  logic [1:0]       cfg_dst_ctl,
   input  logic             cfg_word,
   input  logic             cfg_repeat,
   input  logic [1:0]       cfg_timing,
   input  logic             cfg_irq_en,
   input  logic             vblank_pls,
   input  logic             hblank_pls,
   output logic             bus_req,
   input  logic             bus_gnt,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             mem_wdata_oe,
   input  logic [31:0]      mem_rdata,
   output logic [1:0]       mem_width,
   output logic             mem_read,
   output logic             mem_write,
   input  logic             mem_ok,
   output logic             irq,
   output logic             enable_clr,
   output logic             active
);

   dma_state_t        state, state_n;
   dma_cfg_t          cfg_r, cfg_n, cfg_in;
   logic [ADDR_W-1:0] src_r, src_n, src_step;
   logic [ADDR_W-1:0] dst_r, dst_n, dst_step;
   logic [CNT_W-1:0]  cnt_r, cnt_n;
   logic [31:0]       data_r, data_n;
   logic [15:0]       rd_half;
   logic              en_q;
   logic              abort_r, abort_n;
   logic              wr_first_r, wr_first_n;
   logic              rd_phase_n, wr_phase_n, rearm;

   function automatic logic [ADDR_W-1:0] align_unit(input logic [31:0] a, input logic word);
      logic [ADDR_W-1:0] r;
      r    = a[ADDR_W-1:0];
      r[0] = 1'b0;
      if (word) r[1] = 1'b0;
      return r;
   endfunction

   assign cfg_in = '{word:    cfg_word,
                     src_ctl: dma_ctl_t'(cfg_src_ctl),
                     dst_ctl: dma_ctl_t'(cfg_dst_ctl),
                     timing:  dma_timing_t'(cfg_timing),
                     rpt:     cfg_repeat,
                     irq_en:  cfg_irq_en};

   dma_addr_step #(.ADDR_W(ADDR_W)) u_src_step (
      .addr (src_r),
      .ctl  (cfg_r.src_ctl),
      .word (cfg_r.word),
      .next (src_step)
   );

   dma_addr_step #(.ADDR_W(ADDR_W)) u_dst_step (
      .addr (dst_r),
      .ctl  (cfg_r.dst_ctl),
      .word (cfg_r.word),
      .next (dst_step)
   );

   // Halfword reads take the lane selected by the source address.
   assign rd_half = src_r[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   assign rearm   = cfg_r.rpt && (cfg_r.timing != TIM_IMM);

   always_comb begin
      state_n    = state;
      cfg_n      = cfg_r;
      src_n      = src_r;
      dst_n      = dst_r;
      cnt_n      = cnt_r;
      data_n     = data_r;
      abort_n    = abort_r;
      wr_first_n = 1'b0;
      unique case (state)
         ST_IDLE: begin
            abort_n = 1'b0;
            if (cfg_enable && !en_q) begin
               cfg_n   = cfg_in;
               src_n   = align_unit(cfg_src, cfg_word);
               dst_n   = align_unit(cfg_dst, cfg_word);
               cnt_n   = cfg_count;
               state_n = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (!cfg_enable) state_n = ST_IDLE;
            else begin
               unique case (cfg_r.timing)
                  TIM_IMM:    state_n = ST_REQ;
                  TIM_VBLANK: if (vblank_pls) state_n = ST_REQ;
                  TIM_HBLANK: if (hblank_pls) state_n = ST_REQ;
                  default:    state_n = ST_ARMED;
               endcase
            end
         end
         ST_REQ: begin
            if (!cfg_enable)  state_n = ST_IDLE;
            else if (bus_gnt) state_n = ST_RD_A;
         end
         ST_RD_A: begin
            if (!cfg_enable) abort_n = 1'b1;
            state_n = ST_RD_D;
         end
         ST_RD_D: begin
            if (!cfg_enable) abort_n = 1'b1;
            if (mem_ok) begin
               data_n     = cfg_r.word ? mem_rdata : {rd_half, rd_half};
               wr_first_n = 1'b1;
               state_n    = ST_WR;
            end
         end
         ST_WR: begin
            if (!cfg_enable) abort_n = 1'b1;
            // The entry cycle never completes, so a halfword RMW stall is always seen.
            if (!wr_first_r && mem_ok) begin
               src_n = src_step;
               dst_n = dst_step;
               cnt_n = cnt_r - CNT_W'(1);
               if (abort_r || !cfg_enable)   state_n = ST_IDLE;
               else if (cnt_r == CNT_W'(1))  state_n = ST_DONE;
               else                          state_n = ST_RD_A;
            end
         end
         ST_DONE: begin
            if (rearm) begin
               cfg_n = cfg_in;
               cnt_n = cfg_count;
               src_n = align_unit(32'(src_r), cfg_word);
               if (cfg_r.dst_ctl == CTL_RELOAD) dst_n = align_unit(cfg_dst, cfg_word);
               else                             dst_n = align_unit(32'(dst_r), cfg_word);
               state_n = ST_ARMED;
            end else begin
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign rd_phase_n = (state_n == ST_RD_A) || (state_n == ST_RD_D);
   assign wr_phase_n = (state_n == ST_WR);

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cfg_r        <= '0;
         src_r        <= '0;
         dst_r        <= '0;
         cnt_r        <= '0;
         data_r       <= '0;
         en_q         <= 1'b0;
         abort_r      <= 1'b0;
         wr_first_r   <= 1'b0;
         bus_req      <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_wdata_oe <= 1'b0;
         mem_width    <= '0;
         mem_read     <= 1'b0;
         mem_write    <= 1'b0;
         irq          <= 1'b0;
         enable_clr   <= 1'b0;
         active       <= 1'b0;
      end else begin
         state        <= state_n;
         cfg_r        <= cfg_n;
         src_r        <= src_n;
         dst_r        <= dst_n;
         cnt_r        <= cnt_n;
         data_r       <= data_n;
         en_q         <= cfg_enable;
         abort_r      <= abort_n;
         wr_first_r   <= wr_first_n;
         bus_req      <= (state_n == ST_REQ) || rd_phase_n || wr_phase_n;
         mem_addr     <= rd_phase_n ? 32'(src_n) : (wr_phase_n ? 32'(dst_n) : '0);
         mem_wdata    <= wr_phase_n ? data_n : '0;
         mem_wdata_oe <= wr_phase_n;
         mem_width    <= (rd_phase_n || wr_phase_n) ? unit_width(cfg_n.word) : 2'b00;
         mem_read     <= rd_phase_n;
         mem_write    <= wr_phase_n;
         irq          <= (state_n == ST_DONE) && cfg_n.irq_en;
         enable_clr   <= (state_n == ST_DONE) && !(cfg_n.rpt && (cfg_n.timing != TIM_IMM));
         active       <= (state_n != ST_IDLE) && (state_n != ST_ARMED);
      end
   end

endmodule

// File: tb/tb_dma_channel.sv
// Directed bench for dma_channel with a word-addressed memory model and io-register
// behaviour (enable cleared on enable_clr) driven from one sequential process.
module tb_dma_channel;

   localparam int CNT_W  = 4;
   localparam int ADDR_W = 28;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cfg_enable;
   logic [31:0]      cfg_src, cfg_dst;
   logic [CNT_W-1:0] cfg_count;
   logic [1:0]       cfg_src_ctl, cfg_dst_ctl, cfg_timing;
   logic             cfg_word, cfg_repeat, cfg_irq_en;
   logic             vblank_pls, hblank_pls;
   logic             bus_req, bus_gnt;
   logic [31:0]      mem_addr, mem_wdata, mem_rdata;
   logic             mem_wdata_oe, mem_read, mem_write, mem_ok;
   logic [1:0]       mem_width;
   logic             irq, enable_clr, active;

   always #5 clk = ~clk;

   dma_channel #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_src(cfg_src), .cfg_dst(cfg_dst),
      .cfg_count(cfg_count), .cfg_src_ctl(cfg_src_ctl), .cfg_dst_ctl(cfg_dst_ctl),
      .cfg_word(cfg_word), .cfg_repeat(cfg_repeat), .cfg_timing(cfg_timing),
      .cfg_irq_en(cfg_irq_en), .vblank_pls(vblank_pls), .hblank_pls(hblank_pls),
      .bus_req(bus_req), .bus_gnt(bus_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata), .mem_width(mem_width),
      .mem_read(mem_read), .mem_write(mem_write), .mem_ok(mem_ok), .irq(irq),
      .enable_clr(enable_clr), .active(active)
   );

   logic [31:0] mem [logic [31:0]];
   logic [31:0] rd_q[$], wr_q[$], wd_q[$];
   logic [1:0]  width_q[$];
   int n_checks = 0, n_pass = 0;
   int data_cyc, act_cyc, irq_cnt, clr_cnt, oe_bad = 0, stall_bad;
   logic        p_read = 1'b0, p_write = 1'b0;
   logic [31:0] p_addr = '0, p_wdata = '0;
   logic [1:0]  p_width = '0;

   function automatic logic [31:0] memrd(input logic [31:0] a);
      if (mem.exists(a >> 2)) return mem[a >> 2];
      return '0;
   endfunction

   task automatic poke(input logic [31:0] a, input logic [31:0] d);
      mem[a >> 2] = d;
   endtask

   task automatic mem_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
      logic [31:0] v;
      v = memrd(a);
      if (w == 2'h2)   v = d;
      else if (a[1])   v[31:16] = d[31:16];
      else             v[15:0]  = d[15:0];
      mem[a >> 2] = v;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: memory acts on the cycle just ended, then the new cycle is sampled.
   task automatic tick();
      logic ok_cur;
      ok_cur = mem_ok;
      @(posedge clk);
      #1;
      if (p_write && ok_cur) mem_store(p_addr, p_wdata, p_width);
      if (p_read) mem_rdata = memrd(p_addr);
      if (mem_read && !p_read) begin rd_q.push_back(mem_addr); width_q.push_back(mem_width); end
      if (mem_write && !p_write) begin wr_q.push_back(mem_addr); wd_q.push_back(mem_wdata); end
      if (mem_read || mem_write) data_cyc++;
      if (active) act_cyc++;
      if (irq) irq_cnt++;
      if (enable_clr) begin clr_cnt++; cfg_enable = 1'b0; end
      if (mem_wdata_oe !== mem_write) oe_bad++;
      p_read  = mem_read;
      p_write = mem_write;
      p_addr  = mem_addr;
      p_wdata = mem_wdata;
      p_width = mem_width;
   endtask

   task automatic clear_stats();
      rd_q.delete(); wr_q.delete(); wd_q.delete(); width_q.delete();
      data_cyc = 0; act_cyc = 0; irq_cnt = 0; clr_cnt = 0;
   endtask

   task automatic start(input logic [31:0] src, input logic [31:0] dst, input logic [CNT_W-1:0] cnt,
                        input logic [1:0] sctl, input logic [1:0] dctl, input logic word,
                        input logic rpt, input logic [1:0] tim);
      cfg_enable = 1'b0;
      tick();
      clear_stats();
      cfg_src = src; cfg_dst = dst; cfg_count = cnt; cfg_src_ctl = sctl; cfg_dst_ctl = dctl;
      cfg_word = word; cfg_repeat = rpt; cfg_timing = tim; cfg_irq_en = 1'b1;
      cfg_enable = 1'b1;
   endtask

   task automatic run_until_inactive(input string tag, input int budget);
      bit seen;
      int n;
      seen = 0;
      for (n = 0; n < budget; n++) begin
         tick();
         if (active) seen = 1;
         else if (seen) break;
      end
      check(tag, 32'(n < budget), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; cfg_enable = 1'b0; cfg_src = '0; cfg_dst = '0; cfg_count = '0;
      cfg_src_ctl = '0; cfg_dst_ctl = '0; cfg_word = 1'b0; cfg_repeat = 1'b0; cfg_timing = '0;
      cfg_irq_en = 1'b0; vblank_pls = 1'b0; hblank_pls = 1'b0; bus_gnt = 1'b1; mem_ok = 1'b1;
      mem_rdata = '0;
      clear_stats();
      for (int i = 0; i < 4; i++) poke(32'h0200_0000 + 4 * i, 32'hA500_0000 + i);
      for (int i = 0; i < 16; i++) poke(32'h0200_0200 + 4 * i, 32'h5A00_0000 + i);
      for (int i = 0; i < 4; i++) poke(32'h0200_0300 + 4 * i, 32'hC000_0000 + i);
      poke(32'h0300_001C, 32'hBEEF_1234);
      poke(32'h0300_0018, 32'h5678_9ABC);
      poke(32'h0200_0400, 32'hDEAD_F00D);

      tick(); tick(); tick();
      check("reset_strobes", {25'd0, bus_req, mem_read, mem_write, mem_wdata_oe, irq, enable_clr, active}, 32'd0);
      check("reset_addr", mem_addr, 32'd0);
      check("reset_width_wdata", {mem_width, mem_wdata[29:0]}, 32'd0);
      rst_n = 1'b1;
      tick(); tick();
      check("idle_after_reset", 32'(act_cyc), 32'd0);

      // 1: immediate word copy, inc/inc, 4 units
      start(32'h0200_0000, 32'h0300_0000, 4'd4, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0);
      run_until_inactive("t1_timeout", 60);
      check("t1_reads", 32'(rd_q.size()), 32'd4);
      check("t1_writes", 32'(wr_q.size()), 32'd4);
      check("t1_rd0", rd_q[0], 32'h0200_0000);
      check("t1_rd3", rd_q[3], 32'h0200_000C);
      check("t1_wr3", wr_q[3], 32'h0300_000C);
      check("t1_wd2", wd_q[2], 32'hA500_0002);
      check("t1_width", 32'(width_q[0]), 32'd2);
      check("t1_data_cycles", 32'(data_cyc), 32'd16);
      check("t1_active_cycles", 32'(act_cyc), 32'd18);
      check("t1_irq", 32'(irq_cnt), 32'd1);
      check("t1_enable_clr", 32'(clr_cnt), 32'd1);
      check("t1_mem_last", memrd(32'h0300_000C), 32'hA500_0003);

      // 2: halfword, src decrementing
      start(32'h0300_001E, 32'h0200_0100, 4'd3, 2'd1, 2'd0, 1'b0, 1'b0, 2'd0);
      run_until_inactive("t2_timeout", 60);
      check("t2_rd0", rd_q[0], 32'h0300_001E);
      check("t2_rd1", rd_q[1], 32'h0300_001C);
      check("t2_rd2", rd_q[2], 32'h0300_001A);
      check("t2_width", 32'(width_q[1]), 32'd1);
      check("t2_wd0", wd_q[0], 32'hBEEF_BEEF);
      check("t2_wd2", wd_q[2], 32'h5678_5678);
      check("t2_wr1", wr_q[1], 32'h0200_0102);
      check("t2_mem0", memrd(32'h0200_0100), 32'h1234_BEEF);
      check("t2_mem1", memrd(32'h0200_0104), 32'h0000_5678);

      // 3: count 0 means 2**CNT_W units
      start(32'h0200_0200, 32'h0300_0200, 4'd0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0);
      run_until_inactive("t3_timeout", 120);
      check("t3_writes", 32'(wr_q.size()), 32'd16);
      check("t3_reads", 32'(rd_q.size()), 32'd16);
      check("t3_wr_last", wr_q[15], 32'h0300_023C);
      check("t3_mem_last", memrd(32'h0300_023C), 32'h5A00_000F);

      // 4: vblank-triggered repeat with dst reload
      start(32'h0200_0300, 32'h0300_0300, 4'd2, 2'd0, 2'd3, 1'b1, 1'b1, 2'd1);
      for (int i = 0; i < 8; i++) tick();
      hblank_pls = 1'b1; tick(); hblank_pls = 1'b0;
      tick(); tick(); tick();
      check("t4_no_start", 32'(act_cyc + rd_q.size()), 32'd0);
      vblank_pls = 1'b1; tick(); vblank_pls = 1'b0;
      run_until_inactive("t4_blk1_timeout", 40);
      check("t4_blk1_writes", 32'(wr_q.size()), 32'd2);
      check("t4_blk1_wr1", wr_q[1], 32'h0300_0304);
      check("t4_blk1_irq", 32'(irq_cnt), 32'd1);
      clear_stats();
      vblank_pls = 1'b1; tick(); vblank_pls = 1'b0;
      tick(); tick();
      vblank_pls = 1'b1; tick(); vblank_pls = 1'b0;
      run_until_inactive("t4_blk2_timeout", 40);
      for (int i = 0; i < 6; i++) tick();
      check("t4_blk2_reads", 32'(rd_q.size()), 32'd2);
      check("t4_blk2_rd0", rd_q[0], 32'h0200_0308);
      check("t4_blk2_wr0", wr_q[0], 32'h0300_0300);
      check("t4_blk2_mem", memrd(32'h0300_0304), 32'hC000_0003);
      check("t4_no_enable_clr", 32'(clr_cnt), 32'd0);
      cfg_enable = 1'b0;
      tick(); tick();

      // 5: memory stalls in RD_D and in WR
      start(32'h0200_0400, 32'h0300_0400, 4'd1, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0);
      for (int i = 0; i < 20 && !mem_read; i++) tick();
      tick();
      stall_bad = 0;
      mem_ok = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (!(mem_read && !mem_write && mem_addr == 32'h0200_0400)) stall_bad++;
      end
      mem_ok = 1'b1;
      tick();
      tick();
      mem_ok = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (!(mem_write && !mem_read && mem_addr == 32'h0300_0400 && mem_wdata == 32'hDEAD_F00D)) stall_bad++;
      end
      mem_ok = 1'b1;
      run_until_inactive("t5_timeout", 20);
      check("t5_held_stable", 32'(stall_bad), 32'd0);
      check("t5_data_cycles", 32'(data_cyc), 32'd14);
      check("t5_mem", memrd(32'h0300_0400), 32'hDEAD_F00D);

      // 6: enable dropped during unit 2 of 4
      poke(32'h0300_0008, 32'h5E57_1E00);
      start(32'h0200_0000, 32'h0300_0000, 4'd4, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0);
      for (int i = 0; i < 40 && rd_q.size() < 2; i++) tick();
      cfg_enable = 1'b0;
      run_until_inactive("t6_timeout", 20);
      check("t6_writes", 32'(wr_q.size()), 32'd2);
      check("t6_irq_clr", 32'(irq_cnt + clr_cnt), 32'd0);
      check("t6_mem_unit2", memrd(32'h0300_0004), 32'hA500_0001);
      check("t6_mem_untouched", memrd(32'h0300_0008), 32'h5E57_1E00);
      check("t6_bus_released", 32'(bus_req), 32'd0);

      // async reset in the middle of a write
      start(32'h0200_0000, 32'h0300_0100, 4'd4, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0);
      for (int i = 0; i < 20 && !mem_write; i++) tick();
      check("rst_reached_wr", 32'(mem_write), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_strobes", {26'd0, bus_req, mem_read, mem_write, mem_wdata_oe, active, irq}, 32'd0);
      check("rst_async_addr", mem_addr, 32'd0);
      cfg_enable = 1'b0;
      #1 rst_n = 1'b1;
      tick(); tick();
      check("rst_stays_idle", 32'(active), 32'd0);

      check("oe_tracks_write", 32'(oe_bad), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
